// File: rtl/ins_mem_sync_if.sv
// Fetch, back-pressure and program-load signals for the synchronous instruction memory.
// The master drives requests and writes; the slave (the memory) returns instructions.
interface ins_mem_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic [DATA_W-1:0] ins;
  logic              ins_valid;
  logic              ins_stall;
  logic              ins_err;
  logic              load_mode;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output rd_req, rd_addr, ins_stall, load_mode, wr_en, wr_addr, wr_data,
    input  rd_ready, ins, ins_valid, ins_err, fetch_cnt
  );

  modport slave (
    input  rd_req, rd_addr, ins_stall, load_mode, wr_en, wr_addr, wr_data,
    output rd_ready, ins, ins_valid, ins_err, fetch_cnt
  );
endinterface

// File: rtl/ins_mem_sync.sv
// Instruction memory with one-cycle registered fetch, consumer back-pressure and a
// run-time program-load port; out-of-range fetches return NOP_WORD with ins_err set.
module ins_mem_sync #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  parameter int                CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  ins_mem_sync_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] ins_q, ins_d;
  logic              ins_valid_q, ins_valid_d;
  logic              ins_err_q, ins_err_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic              rd_ready;
  logic              accept;
  logic              hold;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;

  assign rd_in_range = 32'(bus.rd_addr) < DEPTH;
  assign wr_in_range = 32'(bus.wr_addr) < DEPTH;
  assign rd_idx      = bus.rd_addr[IDX_W-1:0];
  assign wr_idx      = bus.wr_addr[IDX_W-1:0];

  // A stalled valid instruction blocks new fetches so it is never overwritten.
  assign hold     = ins_valid_q && bus.ins_stall;
  assign rd_ready = !bus.load_mode && !hold;
  assign accept   = bus.rd_req && rd_ready;

  always_comb begin
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    ins_err_d   = ins_err_q;
    if (accept) begin
      ins_d       = rd_in_range ? mem_q[rd_idx] : NOP_WORD;
      ins_err_d   = !rd_in_range;
      ins_valid_d = 1'b1;
    end else if (!hold) begin
      ins_valid_d = 1'b0;
      ins_err_d   = 1'b0;
    end
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (accept && (fetch_cnt_q != {CNT_W{1'b1}})) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      ins_err_q   <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      ins_err_q   <= ins_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Array is never reset; contents come only from the load port.
  always_ff @(posedge clk) begin
    if (!rst && bus.load_mode && bus.wr_en && wr_in_range) begin
      mem_q[wr_idx] <= bus.wr_data;
    end
  end

  assign bus.rd_ready  = rd_ready;
  assign bus.ins       = ins_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.ins_err   = ins_err_q;
  assign bus.fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_ins_mem_sync.sv
// Directed vector table plus randomized traffic for ins_mem_sync, checked against a
// transaction-level reference model; two instances share stimulus (16-bit and 3-bit counters).
module tb_ins_mem_sync;
  localparam int DEPTH = 200;
  localparam logic [15:0] NOP = 16'h0000;
  localparam int W0 = 'o001200;
  localparam int W1 = 'o011001;
  localparam int W2 = 'o021002;

  typedef struct {
    logic        rst, load, we;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic        req;
    logic [7:0]  ra;
    logic        stall;
    logic        rdy, v, e, ci;
    logic [15:0] ins;
    int          cnt, cntb;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_mem_sync_if #(.DATA_W(16), .ADDR_W(8), .CNT_W(16)) bus_a ();
  ins_mem_sync_if #(.DATA_W(16), .ADDR_W(8), .CNT_W(3))  bus_b ();

  assign bus_b.rd_req    = bus_a.rd_req;
  assign bus_b.rd_addr   = bus_a.rd_addr;
  assign bus_b.ins_stall = bus_a.ins_stall;
  assign bus_b.load_mode = bus_a.load_mode;
  assign bus_b.wr_en     = bus_a.wr_en;
  assign bus_b.wr_addr   = bus_a.wr_addr;
  assign bus_b.wr_data   = bus_a.wr_data;

  ins_mem_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .NOP_WORD(NOP), .CNT_W(16))
    u_dut (.clk(clk), .rst(rst), .bus(bus_a));
  ins_mem_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(DEPTH), .NOP_WORD(NOP), .CNT_W(3))
    u_sat (.clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: memory contents, the instruction on offer, accepted-fetch total
  logic [15:0] m_mem [256];
  bit          m_v, m_e, m_chk;
  logic [15:0] m_ins;
  int          m_cnt;

  vec_t tab[30];
  int   n_tab;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit ld, bit we, int wa, int wd, bit rq, int ra, bit st,
                              bit rdy, bit v, bit e, bit ci, int ins, int cnt, int cntb);
    vec_t t;
    t.rst = r; t.load = ld; t.we = we; t.wa = 8'(wa); t.wd = 16'(wd);
    t.req = rq; t.ra = 8'(ra); t.stall = st;
    t.rdy = rdy; t.v = v; t.e = e; t.ci = ci; t.ins = 16'(ins); t.cnt = cnt; t.cntb = cntb;
    return t;
  endfunction

  function automatic int sat(int n, int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic step(input vec_t v, input bit use_tab);
    bit rdy_m;
    rst             = v.rst;
    bus_a.load_mode = v.load;
    bus_a.wr_en     = v.we;
    bus_a.wr_addr   = v.wa;
    bus_a.wr_data   = v.wd;
    bus_a.rd_req    = v.req;
    bus_a.rd_addr   = v.ra;
    bus_a.ins_stall = v.stall;
    #1;
    rdy_m = !v.load && !(m_v && v.stall);
    chk("rd_ready", {31'd0, bus_a.rd_ready}, {31'd0, rdy_m});
    if (use_tab) chk("tab_rd_ready", {31'd0, bus_a.rd_ready}, {31'd0, v.rdy});

    if (v.rst) begin
      m_v = 0; m_e = 0; m_ins = '0; m_cnt = 0; m_chk = 1;
    end else begin
      if (v.req && rdy_m) begin
        m_cnt++;
        m_e   = (int'(v.ra) >= DEPTH);
        m_ins = m_e ? NOP : m_mem[v.ra];
        m_v   = 1;
      end else if (!(m_v && v.stall)) begin
        m_v = 0; m_e = 0;
      end
      m_chk = m_v;
      if (v.load && v.we && int'(v.wa) < DEPTH) m_mem[v.wa] = v.wd;
    end

    @(negedge clk);
    cyc++;
    chk("ins_valid", {31'd0, bus_a.ins_valid}, {31'd0, m_v});
    chk("ins_err", {31'd0, bus_a.ins_err}, {31'd0, m_e});
    if (m_chk) chk("ins", {16'd0, bus_a.ins}, {16'd0, m_ins});
    chk("fetch_cnt", {16'd0, bus_a.fetch_cnt}, 32'(sat(m_cnt, 65535)));
    chk("fetch_cnt_sat", {29'd0, bus_b.fetch_cnt}, 32'(sat(m_cnt, 7)));
    chk("sat_valid", {31'd0, bus_b.ins_valid}, {31'd0, m_v});
    if (use_tab) begin
      chk("tab_valid", {31'd0, bus_a.ins_valid}, {31'd0, v.v});
      chk("tab_err", {31'd0, bus_a.ins_err}, {31'd0, v.e});
      if (v.ci) chk("tab_ins", {16'd0, bus_a.ins}, {16'd0, v.ins});
      chk("tab_cnt", {16'd0, bus_a.fetch_cnt}, 32'(v.cnt));
      chk("tab_cnt_sat", {29'd0, bus_b.fetch_cnt}, 32'(v.cntb));
    end
  endtask

  initial begin
    vec_t  rv;
    bit    ld_mode;
    int    k;

    bus_a.load_mode = 0; bus_a.wr_en = 0; bus_a.wr_addr = 0; bus_a.wr_data = 0;
    bus_a.rd_req = 0; bus_a.rd_addr = 0; bus_a.ins_stall = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    m_v = 0; m_e = 0; m_ins = '0; m_cnt = 0; m_chk = 1;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    // Load every in-range word so later random fetches see defined data
    for (int i = 0; i < DEPTH; i++) begin
      rv = mk(0, 1, 1, i, $urandom_range(0, 65535), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(rv, 0);
    end

    n_tab = 0;
    tab[n_tab++] = mk(1, 0, 0, 0, 0,        0, 0,   0,  1, 0, 0, 1, 0,  0, 0);
    tab[n_tab++] = mk(0, 1, 1, 0, W0,       0, 0,   0,  0, 0, 0, 0, 0,  0, 0);
    tab[n_tab++] = mk(0, 1, 1, 1, W1,       0, 0,   0,  0, 0, 0, 0, 0,  0, 0);
    tab[n_tab++] = mk(0, 1, 1, 2, W2,       0, 0,   0,  0, 0, 0, 0, 0,  0, 0);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 0,   0,  1, 1, 0, 1, W0, 1, 1);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 1,   0,  1, 1, 0, 1, W1, 2, 2);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 2,   0,  1, 1, 0, 1, W2, 3, 3);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 0,   0,  1, 1, 0, 1, W0, 4, 4);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 1,   1,  0, 1, 0, 1, W0, 4, 4);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 1,   1,  0, 1, 0, 1, W0, 4, 4);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 1,   0,  1, 1, 0, 1, W1, 5, 5);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 200, 0,  1, 1, 1, 1, 0,  6, 6);
    tab[n_tab++] = mk(0, 1, 1, 250, 'h1234, 0, 0,   0,  0, 0, 0, 0, 0,  6, 6);
    tab[n_tab++] = mk(0, 1, 0, 0, 0,        1, 0,   0,  0, 0, 0, 0, 0,  6, 6);
    tab[n_tab++] = mk(0, 0, 1, 0, 'o177777, 0, 0,   0,  1, 0, 0, 0, 0,  6, 6);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 0,   0,  1, 1, 0, 1, W0, 7, 7);
    tab[n_tab++] = mk(0, 1, 0, 0, 0,        1, 1,   1,  0, 1, 0, 1, W0, 7, 7);
    tab[n_tab++] = mk(0, 1, 0, 0, 0,        1, 1,   0,  0, 0, 0, 0, 0,  7, 7);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 2,   0,  1, 1, 0, 1, W2, 8, 7);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 0,   1,  0, 1, 0, 1, W2, 8, 7);
    tab[n_tab++] = mk(1, 0, 0, 0, 0,        1, 0,   1,  0, 0, 0, 1, 0,  0, 0);
    tab[n_tab++] = mk(0, 0, 0, 0, 0,        1, 0,   0,  1, 1, 0, 1, W0, 1, 1);
    for (k = 1; k <= 8; k++) begin
      tab[n_tab++] = mk(0, 0, 0, 0, 0, 1, k % 3, 0, 1, 1, 0, 1,
                        (k % 3 == 0) ? W0 : ((k % 3 == 1) ? W1 : W2), k + 1, sat(k + 1, 7));
    end

    for (int i = 0; i < n_tab; i++) begin
      step(tab[i], 1);
      $display("vec %0d: req=%0b addr=%0d stall=%0b load=%0b -> valid=%0b err=%0b ins=%o cnt=%0d/%0d",
               i, tab[i].req, tab[i].ra, tab[i].stall, tab[i].load,
               bus_a.ins_valid, bus_a.ins_err, bus_a.ins, bus_a.fetch_cnt, bus_b.fetch_cnt);
    end

    ld_mode = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) ld_mode = !ld_mode;
      rv = mk($urandom_range(0, 99) == 0, ld_mode, $urandom_range(0, 1),
              $urandom_range(0, 255), $urandom_range(0, 65535),
              $urandom_range(0, 3) != 0, $urandom_range(0, 255),
              $urandom_range(0, 2) == 0, 0, 0, 0, 0, 0, 0, 0);
      step(rv, 0);
    end
    $display("random phase: %0d cycles, model fetch total %0d", 2000, m_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
